// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand forwarding unit.
//   fwd_entry_t : one in-flight writer slot {valid, rd, is_load}
//   fwd_sel_e   : operand source select (register file, pipeline stage, pc/imm)
//   legality helpers used at elaboration to reject illegal parameter sets
package fwd_pkg;

  localparam int DEPTH_MIN    = 2;
  localparam int DEPTH_MAX    = 6;
  localparam int LOAD_LAT_MIN = 1;
  // The entry struct has a fixed register field; narrower addresses are zero-extended.
  localparam int REG_AW_MAX   = 8;
  // Enough bits to index up to DEPTH_MAX entries.
  localparam int IDX_W        = 3;
  localparam int CNT_W        = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef logic [REG_AW_MAX-1:0] fwd_rd_t;

  typedef struct packed {
    logic    valid;
    fwd_rd_t rd;
    logic    is_load;
  } fwd_entry_t;

  typedef enum logic [1:0] {
    SEL_RF    = 2'd0,
    SEL_STAGE = 2'd1,
    SEL_ALT   = 2'd2
  } fwd_sel_e;

  function automatic logic depth_legal(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  function automatic logic load_lat_legal(input int load_lat, input int depth);
    return (load_lat >= LOAD_LAT_MIN) && (load_lat <= depth - 1);
  endfunction

  function automatic logic reg_aw_legal(input int reg_aw);
    return (reg_aw >= 1) && (reg_aw <= REG_AW_MAX);
  endfunction

  // A load result only exists once the writer has reached the load-data stage.
  function automatic logic entry_ready(input logic is_load, input int k, input int load_lat);
    return (!is_load) || (k >= load_lat);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one decode source register against every scoreboard entry.
// Ports:
//   check   : source is actually read by the instruction (not replaced by pc/imm)
//   src     : source register address
//   entries : scoreboard, entry 0 = youngest (EX), DEPTH-1 = oldest (WB)
//   hit     : some valid entry writes src (r0 never hits)
//   idx     : index of the youngest matching entry
//   ready   : youngest match can forward this cycle
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic                   check,
  input  logic [REG_AW-1:0]      src,
  input  fwd_entry_t [DEPTH-1:0] entries,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic                   ready
);

  fwd_rd_t src_ext_s;
  assign src_ext_s = REG_AW_MAX'(src);

  // Scan oldest to youngest so the youngest match is the one left standing;
  // an older ready writer therefore can never mask a younger unready load.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (check && (src != '0) && entries[k].valid && (entries[k].rd == src_ext_s)) begin
        hit   = 1'b1;
        idx   = IDX_W'(k);
        ready = entry_ready(entries[k].is_load, k, LOAD_LAT);
      end else begin
        // no match here: keep whatever older match was found
      end
    end
  end

endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding / load-use interlock for a short in-order pipeline.
// Tracks DEPTH in-flight writers, forwards their results into the decode
// operands, stalls decode on a load whose data is not yet available, and
// registers the selected operands into EX.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_valid            : decode instruction present
//   rs1, rs2, rd        : decode source/destination registers
//   rd_we, is_load      : decode writes rd / is a load
//   use_pc, use_imm     : op1 takes pc / op2 takes imm
//   rd1, rd2, imm, pc   : register-file reads, immediate, program counter
//   stage_data          : result of entry k on bits [k*OP_SIZE +: OP_SIZE]
//   flush               : kill the decode instruction
//   op1, op2, ex_valid  : registered EX operands and their valid
//   stall               : combinational decode hold
//   stall_cnt           : saturating stall-cycle counter
module operand_fwd_unit
  import fwd_pkg::*;
#(
  parameter int OP_SIZE  = 24,
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        rs1,
  input  logic [REG_AW-1:0]        rs2,
  input  logic [REG_AW-1:0]        rd,
  input  logic                     rd_we,
  input  logic                     is_load,
  input  logic                     use_pc,
  input  logic                     use_imm,
  input  logic [OP_SIZE-1:0]       rd1,
  input  logic [OP_SIZE-1:0]       rd2,
  input  logic [OP_SIZE-1:0]       imm,
  input  logic [OP_SIZE-1:0]       pc,
  input  logic [DEPTH*OP_SIZE-1:0] stage_data,
  input  logic                     flush,
  output logic [OP_SIZE-1:0]       op1,
  output logic [OP_SIZE-1:0]       op2,
  output logic                     ex_valid,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Illegal parameter sets stop elaboration.
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("operand_fwd_unit: DEPTH must be within 2..6");
  end
  if (!load_lat_legal(LOAD_LAT, DEPTH)) begin : g_bad_load_lat
    $error("operand_fwd_unit: LOAD_LAT must be within 1..DEPTH-1");
  end
  if (!reg_aw_legal(REG_AW)) begin : g_bad_reg_aw
    $error("operand_fwd_unit: REG_AW must be within 1..8");
  end

  fwd_entry_t [DEPTH-1:0] sb_r;
  fwd_entry_t             new_entry_s;

  logic                   hit1_s;
  logic                   hit2_s;
  logic                   rdy1_s;
  logic                   rdy2_s;
  logic [IDX_W-1:0]       idx1_s;
  logic [IDX_W-1:0]       idx2_s;
  logic                   stall_s;
  logic                   accept_s;
  fwd_sel_e               sel1_s;
  fwd_sel_e               sel2_s;
  logic [OP_SIZE-1:0]     fwd1_s;
  logic [OP_SIZE-1:0]     fwd2_s;
  logic [OP_SIZE-1:0]     op1_nxt_s;
  logic [OP_SIZE-1:0]     op2_nxt_s;

  logic [OP_SIZE-1:0]     op1_r;
  logic [OP_SIZE-1:0]     op2_r;
  logic                   ex_valid_r;
  logic [CNT_W-1:0]       stall_cnt_r;

  fwd_match #(
    .DEPTH    (DEPTH),
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_match1 (
    .check   (~use_pc),
    .src     (rs1),
    .entries (sb_r),
    .hit     (hit1_s),
    .idx     (idx1_s),
    .ready   (rdy1_s)
  );

  fwd_match #(
    .DEPTH    (DEPTH),
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_match2 (
    .check   (~use_imm),
    .src     (rs2),
    .entries (sb_r),
    .hit     (hit2_s),
    .idx     (idx2_s),
    .ready   (rdy2_s)
  );

  // Flush wins over stall: a killed instruction never holds the front end.
  assign stall_s  = id_valid & ~flush & ((hit1_s & ~rdy1_s) | (hit2_s & ~rdy2_s));
  assign accept_s = id_valid & ~flush & ~stall_s;

  // Build the entry pushed into slot 0 this cycle (bubble unless a real write issues).
  always_comb begin
    new_entry_s = '0;
    if (accept_s && rd_we && (rd != '0)) begin
      new_entry_s.valid   = 1'b1;
      new_entry_s.rd      = REG_AW_MAX'(rd);
      new_entry_s.is_load = is_load;
    end else begin
      new_entry_s = '0;
    end
  end

  // Pick the forwarded result of the matching entry for each source.
  always_comb begin
    fwd1_s = '0;
    fwd2_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (idx1_s == IDX_W'(k)) begin
        fwd1_s = stage_data[k*OP_SIZE +: OP_SIZE];
      end else begin
        // other entry selected
      end
      if (idx2_s == IDX_W'(k)) begin
        fwd2_s = stage_data[k*OP_SIZE +: OP_SIZE];
      end else begin
        // other entry selected
      end
    end
  end

  // Decide the source of each operand.
  always_comb begin
    sel1_s = SEL_RF;
    sel2_s = SEL_RF;
    if (use_pc) begin
      sel1_s = SEL_ALT;
    end else if (hit1_s) begin
      sel1_s = SEL_STAGE;
    end else begin
      sel1_s = SEL_RF;
    end
    if (use_imm) begin
      sel2_s = SEL_ALT;
    end else if (hit2_s) begin
      sel2_s = SEL_STAGE;
    end else begin
      sel2_s = SEL_RF;
    end
  end

  // Operand muxes driven by the select enums.
  always_comb begin
    op1_nxt_s = '0;
    op2_nxt_s = '0;
    case (sel1_s)
      SEL_RF:    op1_nxt_s = rd1;
      SEL_STAGE: op1_nxt_s = fwd1_s;
      SEL_ALT:   op1_nxt_s = pc;
      default:   op1_nxt_s = '0;
    endcase
    case (sel2_s)
      SEL_RF:    op2_nxt_s = rd2;
      SEL_STAGE: op2_nxt_s = fwd2_s;
      SEL_ALT:   op2_nxt_s = imm;
      default:   op2_nxt_s = '0;
    endcase
  end

  // Scoreboard shift: slot 0 takes the new entry, the oldest slot retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= '0;
    end else begin
      sb_r[0] <= new_entry_s;
      for (int k = 1; k < DEPTH; k++) begin
        sb_r[k] <= sb_r[k-1];
      end
    end
  end

  // EX operand registers; dead slots carry zero operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_r      <= '0;
      op2_r      <= '0;
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      op1_r      <= op1_nxt_s;
      op2_r      <= op2_nxt_s;
      ex_valid_r <= 1'b1;
    end else begin
      op1_r      <= '0;
      op2_r      <= '0;
      ex_valid_r <= 1'b0;
    end
  end

  // Stall-cycle counter, pinned at all-ones once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign op1       = op1_r;
  assign op2       = op2_r;
  assign ex_valid  = ex_valid_r;
  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 Parameter OP_SIZE, default 24, operand/data width in bits.
REQ-002 Parameter REG_AW, default 4, register-address width (16 registers, r0 hard-wired zero).
REQ-003 Parameter DEPTH, default 3, in-flight writer stages tracked (entry 0 = EX, DEPTH-1 = WB); legal 2..6.
REQ-004 Parameter LOAD_LAT, default 1, first entry index at which a load result is forwardable; legal 1..DEPTH-1.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 id_valid  input  1  decode-stage instruction present.
REQ-008 rs1, rs2, rd  input  REG_AW each  decode source/destination registers.
REQ-009 rd_we, is_load, use_pc, use_imm  input  1 each  decode writes rd / is load / op1 takes pc / op2 takes imm.
REQ-010 rd1, rd2, imm, pc  input  OP_SIZE each  register-file reads, immediate, program counter.
REQ-011 stage_data  input  DEPTH*OP_SIZE  result of entry k on bits [k*OP_SIZE +: OP_SIZE].
REQ-012 flush  input  1  kill decode instruction (branch taken).
REQ-013 op1, op2  output  OP_SIZE each  registered EX operands.
REQ-014 ex_valid  output  1  op1/op2 belong to a live instruction.
REQ-015 stall  output  1  combinational; hold fetch/decode this cycle.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 Scoreboard: DEPTH entries {valid, rd, is_load}; every cycle entry k moves to k+1, entry DEPTH-1 retires.
REQ-018 Entry 0 loads {id_valid & rd_we & rd!=0 & !stall & !flush, rd, is_load}; otherwise a bubble (valid=0).
REQ-019 rs1 checked only when !use_pc; rs2 checked only when !use_imm; r0 never matches.
REQ-020 Match = valid entry with rd equal to the source; youngest (lowest k) match wins.
REQ-021 Match ready if !is_load, or is_load and k >= LOAD_LAT; ready match forwards stage_data[k].
REQ-022 stall = id_valid & !flush & (unready youngest match on any checked source); older ready matches never hide an unready younger one.
REQ-023 Operand select: op1 = use_pc ? pc : (match ? fwd : rd1); op2 = use_imm ? imm : (match ? fwd : rd2).
REQ-024 Operands and ex_valid registered; latency 1 cycle from decode to op1/op2.
REQ-025 ex_valid next = id_valid & !stall & !flush; when 0, op1/op2 load 0.
REQ-026 flush has priority over stall; flush with stall pending drops the instruction, no stall asserted.
REQ-027 stall_cnt increments each stall cycle, saturates at 0xFFFF, never wraps.
REQ-028 Same rd in multiple entries: only youngest considered (REQ-020).

Reset
REQ-029 rst_n low: all entries invalid, op1=op2=0, ex_valid=0, stall_cnt=0, immediate regardless of clk.
REQ-030 Reset mid-stall: stall deasserts on reset; first cycle after release sees empty scoreboard.

Structure
REQ-031 Package fwd_pkg holds entry struct typedef, fwd-select enum (SEL_RF, SEL_STAGE, SEL_ALT), and DEPTH/LOAD_LAT legality constants.
REQ-032 Sub-module fwd_match (one source vs all entries -> hit, index, ready) instantiated twice.
REQ-033 Parameter legality checked at elaboration; illegal values fail build.

Verification
REQ-034 ALU r3 in entry 0, decode rs1=r3, stage_data[0]=0x00ABCD -> next cycle op1=0x00ABCD, stall=0.
REQ-035 Load r5 in entry 0 (LOAD_LAT=1), decode rs2=r5, use_imm=0 -> stall=1 one cycle, bubble, then op2=stage_data[1], stall_cnt=1.
REQ-036 r4 in entries 0 and 2 with data 0x000011/0x000022, rs1=r4 -> op1=0x000011.
REQ-037 rd=r0 writer, then rs1=r0, rd1=0 -> op1=0, no forward, no stall.
REQ-038 Load-use stall plus flush same cycle -> stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
REQ-039 rst_n low during stall -> op1=op2=0, ex_valid=0, stall=0 immediately; stall_cnt 0xFFFF held after further stalls pre-reset.
